ecap5_dwbgpio: RTL and testbench
================================

Name: ecap5_dwbgpio

Overview:
- Wishbone pipelined slave (responder) exposing general-purpose outputs (LEDs) and debounced inputs (buttons) to the core's master bus.
- Sits behind the SoC top-level address decoder, alongside the BRAM and UART slaves.
- Provides an output register with set/clear aliases, synchronized and debounced inputs, and sticky rising-edge event flags with an interrupt output.

Parameters:
- NB_OUTPUTS, 2, number of gpio_o bits (1..32).
- NB_INPUTS, 2, number of gpio_i bits (1..32).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before the debounced value changes (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous to clk_i, active-high.
- wb_adr_i  in  32  byte address; only bits [4:2] decoded, other bits ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid while wb_ack_o=1.
- wb_sel_i  in  4  byte enables for writes.
- wb_we_i  in  1  1=write, 0=read.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  response.
- wb_stall_o  out  1  back-pressure; always 0.
- gpio_o  out  NB_OUTPUTS  output pins, driven directly from OUT.
- gpio_i  in  NB_INPUTS  asynchronous input pins.
- irq_o  out  1  registered; equals |(EVT & IRQ_EN).

Behaviour:
- Reset (rst_i=1 at a rising edge): OUT, IRQ_EN, EVT, sync flops, debounced value and counters cleared to 0. Outputs: wb_ack_o=0, wb_dat_o=0, wb_stall_o=0, gpio_o=0, irq_o=0. A request accepted in the cycle before reset is discarded; no ack is issued.
- Acceptance: a request is accepted in any cycle with wb_cyc_i & wb_stb_i. There is no stall.
- Response: wb_ack_o=1 exactly one cycle after acceptance, with wb_dat_o. Back-to-back requests give back-to-back acks. wb_dat_o=0 when no ack.
- Write timing: write side effects take effect at the accepting edge. A read returns register state from before that edge.
- Byte enables: a write affects only bytes i where wb_sel_i[i]=1. Bits above NB_* are ignored on write and read as 0.
- Register map (offset, access):
  - 0x00 OUT, RW.
  - 0x04 OUT_SET, WO: writing 1 sets the OUT bit; reads 0.
  - 0x08 OUT_CLR, WO: writing 1 clears the OUT bit; reads 0.
  - 0x0C IN, RO: debounced inputs; writes ignored.
  - 0x10 EVT, RW1C.
  - 0x14 IRQ_EN, RW.
  - 0x18/0x1C: reads 0, writes ignored; still acked.
- Input path, per bit:
  - 2-flop synchronizer, then a debounce counter.
  - Counter resets to 0 whenever the synchronized value equals the debounced value.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the values still differ, the debounced bit toggles and the counter resets.
  - Total latency from a gpio_i step to IN change is 2+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes IN.
- Events: an EVT bit is set in the cycle after its debounced bit goes 0->1. A falling debounced edge sets nothing.
- Simultaneous event set and W1C on the same bit in the same cycle: set wins, bit stays 1.
- irq_o updates one cycle after EVT/IRQ_EN change.
- Debounce counter width: $clog2(DEBOUNCE_CYCLES+1). The counter never wraps.

Test Plan:
- Reset -> gpio_o=0, irq_o=0, wb_ack_o=0; read 0x0C with gpio_i=0 gives ack next cycle, dat=0.
- Write 0x00 data 0x3 sel 0x1 -> gpio_o=2'b11 the cycle after accept. Then write 0x08 data 0x1 -> gpio_o=2'b10. Then write 0x04 data 0x1 -> 2'b11. Then write 0x00 data 0x0 sel 0x0 -> unchanged.
- gpio_i[0] high for DEBOUNCE_CYCLES-1 cycles then low -> IN stays 0, EVT=0. gpio_i[0] held high -> IN[0]=1 exactly 18 cycles after the step (default), EVT[0]=1 one cycle later.
- IRQ_EN=0x1 with EVT[0]=1 -> irq_o=1. Write 0x10 data 0x1 -> EVT=0, irq_o=0 the following cycle. W1C in the same cycle as a new rising edge -> EVT[0] remains 1.
- Four back-to-back reads (0x00, 0x0C, 0x14, 0x1C) with stb held -> four consecutive acks, stall always 0, data OUT, IN, IRQ_EN, 0 in order.
- Write to 0x00 accepted, rst_i=1 the next cycle -> no ack, gpio_o=0.

Source files
------------

// File: rtl/ecap5_dwbgpio.sv
// Wishbone pipelined GPIO slave: output register with set/clear aliases,
// synchronized + debounced inputs, sticky rising-edge event flags and an
// interrupt line. Single-cycle response, never stalls.
module ecap5_dwbgpio #(
    parameter int NB_OUTPUTS      = 2,
    parameter int NB_INPUTS       = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o,
    output logic                  wb_stall_o,
    output logic [NB_OUTPUTS-1:0] gpio_o,
    input  logic [NB_INPUTS-1:0]  gpio_i,
    output logic                  irq_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] REG_OUT     = 3'd0;
    localparam logic [2:0] REG_OUT_SET = 3'd1;
    localparam logic [2:0] REG_OUT_CLR = 3'd2;
    localparam logic [2:0] REG_IN      = 3'd3;
    localparam logic [2:0] REG_EVT     = 3'd4;
    localparam logic [2:0] REG_IRQ_EN  = 3'd5;

    logic                  req;
    logic                  wr;
    logic [2:0]            reg_sel;
    logic [31:0]           byte_mask;
    logic [NB_OUTPUTS-1:0] out_mask;
    logic [NB_INPUTS-1:0]  in_mask;
    logic [31:0]           rdata;

    logic                  ack_q;
    logic [31:0]           dat_q;
    logic [NB_OUTPUTS-1:0] out_q,    out_d;
    logic [NB_INPUTS-1:0]  irq_en_q, irq_en_d;
    logic [NB_INPUTS-1:0]  evt_q,    evt_d;
    logic                  irq_q;

    logic [NB_INPUTS-1:0]  sync1_q, sync2_q;
    logic [NB_INPUTS-1:0]  deb_q,   deb_d;
    logic [NB_INPUTS-1:0]  deb_prev_q;
    logic [CW-1:0]         cnt_q [NB_INPUTS];
    logic [CW-1:0]         cnt_d [NB_INPUTS];

    logic                  unused_ok;

    assign req     = wb_cyc_i & wb_stb_i;
    assign wr      = req & wb_we_i;
    assign reg_sel = wb_adr_i[4:2];

    // Expand byte enables to a per-bit write mask.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            byte_mask[b*8 +: 8] = {8{wb_sel_i[b]}};
        end
    end

    assign out_mask = byte_mask[NB_OUTPUTS-1:0];
    assign in_mask  = byte_mask[NB_INPUTS-1:0];

    // Read mux over the pre-edge register state; unmapped bits read as 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        rdata = '0;
        case (reg_sel)
            REG_OUT:    rdata[NB_OUTPUTS-1:0] = out_q;
            REG_IN:     rdata[NB_INPUTS-1:0]  = deb_q;
            REG_EVT:    rdata[NB_INPUTS-1:0]  = evt_q;
            REG_IRQ_EN: rdata[NB_INPUTS-1:0]  = irq_en_q;
            default:    rdata = '0;
        endcase
    end

    // Register writes; a new rising debounced edge overrides a same-cycle W1C.
    always_comb begin
        out_d    = out_q;
        irq_en_d = irq_en_q;
        evt_d    = evt_q;
        if (wr) begin
            case (reg_sel)
                REG_OUT:     out_d    = (out_q & ~out_mask) | (wb_dat_i[NB_OUTPUTS-1:0] & out_mask);
                REG_OUT_SET: out_d    = out_q | (wb_dat_i[NB_OUTPUTS-1:0] & out_mask);
                REG_OUT_CLR: out_d    = out_q & ~(wb_dat_i[NB_OUTPUTS-1:0] & out_mask);
                REG_EVT:     evt_d    = evt_q & ~(wb_dat_i[NB_INPUTS-1:0] & in_mask);
                REG_IRQ_EN:  irq_en_d = (irq_en_q & ~in_mask) | (wb_dat_i[NB_INPUTS-1:0] & in_mask);
                default:     ;
            endcase
        end
        evt_d = evt_d | (deb_q & ~deb_prev_q);
    end

    // Debounce: count cycles of disagreement, flip once it has lasted long enough.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB_INPUTS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Bus response and register state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            ack_q    <= 1'b0;
            dat_q    <= '0;
            out_q    <= '0;
            irq_en_q <= '0;
            evt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= req;
            dat_q    <= req ? rdata : '0;
            out_q    <= out_d;
            irq_en_q <= irq_en_d;
            evt_q    <= evt_d;
            irq_q    <= |(evt_q & irq_en_q);
        end
    end

    // Input synchronizer, debounced value and per-bit counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it is cleared on reset like any other state.
            for (int i = 0; i < NB_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= gpio_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < NB_INPUTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A pending response is dropped while reset is asserted.
    assign wb_ack_o   = ack_q & ~rst_i;
    assign wb_dat_o   = rst_i ? 32'd0 : dat_q;
    assign wb_stall_o = 1'b0;
    assign gpio_o     = out_q;
    assign irq_o      = irq_q;

    // Address bits outside [4:2] and data bits above NB_* are intentionally ignored.
    assign unused_ok = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i, byte_mask};

endmodule

// File: tb/tb_ecap5_dwbgpio.sv
// Directed self-checking bench for ecap5_dwbgpio (default parameters).
module tb_ecap5_dwbgpio;

    localparam int DEB     = 16;
    localparam int LATENCY = 2 + DEB;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_stall_o;
    logic [1:0]  gpio_o;
    logic [1:0]  gpio_i;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    ecap5_dwbgpio #(
        .NB_OUTPUTS(2),
        .NB_INPUTS(2),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i),
        .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i),
        .wb_ack_o(wb_ack_o),
        .wb_stall_o(wb_stall_o),
        .gpio_o(gpio_o),
        .gpio_i(gpio_i),
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One single-beat request; returns just after the accepting edge with the ack visible.
    task automatic wb_req(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        step();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wb_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        wb_req(1'b0, adr, 32'd0, 4'h0);
        check({tag, "_ack"}, {31'd0, wb_ack_o}, 32'd1);
        check(tag, wb_dat_o, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i    = 1'b1;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        gpio_i   = '0;
        repeat (3) step();
        rst_i = 1'b0;
        #1;

        // Reset state
        check("rst_gpio",  {30'd0, gpio_o}, 32'd0);
        check("rst_irq",   {31'd0, irq_o}, 32'd0);
        check("rst_ack",   {31'd0, wb_ack_o}, 32'd0);
        check("rst_stall", {31'd0, wb_stall_o}, 32'd0);
        check("rst_dat",   wb_dat_o, 32'd0);
        wb_read("rd_in_rst", 32'h0C, 32'd0);
        step();
        check("idle_ack", {31'd0, wb_ack_o}, 32'd0);
        check("idle_dat", wb_dat_o, 32'd0);

        // Output register and set/clear aliases
        wb_req(1'b1, 32'h00, 32'h3, 4'h1);
        check("wr_out_ack", {31'd0, wb_ack_o}, 32'd1);
        check("wr_out",     {30'd0, gpio_o}, 32'h3);
        wb_req(1'b1, 32'h08, 32'h1, 4'hF);
        check("out_clr", {30'd0, gpio_o}, 32'h2);
        wb_req(1'b1, 32'h04, 32'h1, 4'hF);
        check("out_set", {30'd0, gpio_o}, 32'h3);
        wb_req(1'b1, 32'h00, 32'h0, 4'h0);
        check("out_sel0", {30'd0, gpio_o}, 32'h3);
        wb_req(1'b1, 32'h00, 32'h0, 4'h2);
        check("out_sel_lane1", {30'd0, gpio_o}, 32'h3);
        wb_read("rd_out",     32'h00, 32'h3);
        wb_read("rd_out_set", 32'h04, 32'h0);
        wb_read("rd_out_clr", 32'h08, 32'h0);
        wb_req(1'b1, 32'h0C, 32'hFFFF_FFFF, 4'hF);
        wb_read("rd_in_wr_ign", 32'h0C, 32'h0);

        // Glitch of DEB-1 cycles never reaches IN
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = 32'h0C;
        gpio_i   = 2'b01;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == DEB - 1) gpio_i = 2'b00;
            check("glitch_in", wb_dat_o, 32'd0);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_read("glitch_evt", 32'h10, 32'd0);

        // Held step: IN[0] rises exactly LATENCY edges after the step, EVT one later
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = 32'h0C;
        gpio_i   = 2'b01;
        for (int k = 1; k <= LATENCY + 1; k++) begin
            step();
            check("step_in", wb_dat_o, (k == LATENCY + 1) ? 32'd1 : 32'd0);
        end
        wb_adr_i = 32'h10;
        step();
        check("step_evt", wb_dat_o, 32'd1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        check("step_irq_masked", {31'd0, irq_o}, 32'd0);

        // Interrupt enable and W1C
        wb_req(1'b1, 32'h14, 32'h1, 4'hF);
        check("irq_en_lag", {31'd0, irq_o}, 32'd0);
        step();
        check("irq_on", {31'd0, irq_o}, 32'd1);
        wb_read("rd_irq_en", 32'h14, 32'h1);
        wb_req(1'b1, 32'h10, 32'h1, 4'hF);
        check("w1c_irq_lag", {31'd0, irq_o}, 32'd1);
        step();
        check("w1c_irq_off", {31'd0, irq_o}, 32'd0);
        wb_read("w1c_evt", 32'h10, 32'd0);

        // Falling debounced edge sets nothing
        gpio_i = 2'b00;
        repeat (LATENCY + 7) step();
        wb_read("fall_in",  32'h0C, 32'd0);
        wb_read("fall_evt", 32'h10, 32'd0);
        check("fall_irq", {31'd0, irq_o}, 32'd0);

        // W1C on the same edge as a new event: event wins
        gpio_i = 2'b01;
        repeat (LATENCY) step();
        wb_req(1'b1, 32'h10, 32'h1, 4'hF);
        wb_read("w1c_vs_set_evt", 32'h10, 32'd1);
        check("w1c_vs_set_irq", {31'd0, irq_o}, 32'd1);

        // Back-to-back reads, stb held
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 32'h00;
        step();
        check("b2b0_ack", {31'd0, wb_ack_o}, 32'd1);
        check("b2b0_stall", {31'd0, wb_stall_o}, 32'd0);
        check("b2b0_dat", wb_dat_o, 32'h3);
        wb_adr_i = 32'h0C;
        step();
        check("b2b1_ack", {31'd0, wb_ack_o}, 32'd1);
        check("b2b1_stall", {31'd0, wb_stall_o}, 32'd0);
        check("b2b1_dat", wb_dat_o, 32'h1);
        wb_adr_i = 32'h14;
        step();
        check("b2b2_ack", {31'd0, wb_ack_o}, 32'd1);
        check("b2b2_stall", {31'd0, wb_stall_o}, 32'd0);
        check("b2b2_dat", wb_dat_o, 32'h1);
        wb_adr_i = 32'h1C;
        step();
        check("b2b3_ack", {31'd0, wb_ack_o}, 32'd1);
        check("b2b3_stall", {31'd0, wb_stall_o}, 32'd0);
        check("b2b3_dat", wb_dat_o, 32'h0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        step();
        check("b2b_end_ack", {31'd0, wb_ack_o}, 32'd0);
        check("b2b_end_dat", wb_dat_o, 32'd0);

        // Reserved offsets: acked, writes ignored
        wb_req(1'b1, 32'h18, 32'hFFFF_FFFF, 4'hF);
        check("rsv_wr_ack", {31'd0, wb_ack_o}, 32'd1);
        wb_read("rsv_rd", 32'h18, 32'd0);
        wb_read("rsv_out", 32'h00, 32'h3);

        // Reset right after an accepted write discards the ack
        wb_req(1'b1, 32'h00, 32'h1, 4'h1);
        check("pre_rst_gpio", {30'd0, gpio_o}, 32'h1);
        rst_i = 1'b1;
        #1;
        check("rst_drop_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_drop_dat", wb_dat_o, 32'd0);
        step();
        check("rst_gpio2", {30'd0, gpio_o}, 32'd0);
        check("rst_irq2",  {31'd0, irq_o}, 32'd0);
        check("rst_ack2",  {31'd0, wb_ack_o}, 32'd0);
        rst_i = 1'b0;
        step();
        check("post_rst_ack", {31'd0, wb_ack_o}, 32'd0);
        wb_read("post_rst_irq_en", 32'h14, 32'd0);
        wb_read("post_rst_evt",    32'h10, 32'd0);
        wb_read("post_rst_out",    32'h00, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
